// File: rtl/fetch_stage_if.sv
// Program-memory bus between the fetch stage (master) and a combinational ROM (slave).
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] instr;

  modport master (output addr, input  instr);
  modport slave  (input  addr, output instr);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register, stall/flush/redirect.
// Optional FETCH_STATS_EN adds saturating stall/flush event counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] ifid_instr_o,
  output logic [DATA_WIDTH-1:0] ifid_pc4_o,
  output logic                  ifid_valid_o,
  output logic                  align_err_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
`endif
);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;

  // Wraps modulo 2^DATA_WIDTH with no overflow indication.
  assign pc_plus4  = pc + DATA_WIDTH'(4);
  assign imem.addr = pc;
  assign pc_o      = pc;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it is just the highest-priority branch at the edge.
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_i) begin
      pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    end else if (!stall_i) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register; a redirect without flush still latches the old-PC fetch (delay slot).
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else if (flush_i) begin
      ifid_instr_o <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else if (!stall_i) begin
      ifid_instr_o <= imem.instr;
      ifid_pc4_o   <= pc_plus4;
      ifid_valid_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      align_err_o <= 1'b0;
    end else begin
      align_err_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end
  end

`ifdef FETCH_STATS_EN
  // Stall cycles that were overridden by a flush are not counted as stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_i && !flush_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush_i && (flush_cnt_o != 32'hFFFF_FFFF)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational ROM model.
// Counter checks are compiled in when FETCH_STATS_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic        align_err_o;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage_if #(.DATA_WIDTH(32)) imem ();

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem.master),
    .pc_o          (pc_o),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_valid_o  (ifid_valid_o),
    .align_err_o   (align_err_o)
`ifdef FETCH_STATS_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Word k of the text segment holds 0x20080001 + k*0x00010001.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = (addr - 32'h0040_0000) >> 2;
    return 32'h2008_0001 + idx * 32'h0001_0001;
  endfunction

  assign imem.instr = rom_word(imem.addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic rst, input logic st, input logic fl,
                          input logic rd, input logic [31:0] tgt);
    reset         = rst;
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = tgt;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, ifid_instr_o, instr);
    check({tag, ".pc4"},   ifid_pc4_o,   pc4);
    check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
  endtask

  initial begin
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    check("rst.pc", pc_o, 32'h0040_0000);
    check("rst.addr", imem.addr, 32'h0040_0000);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check("rst.align", {31'd0, align_err_o}, 32'd0);

    // Free run after release.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("run1.pc", pc_o, 32'h0040_0004);
    check_ifid("run1", 32'h2008_0001, 32'h0040_0004, 1'b1);
    tick();
    check("run2.pc", pc_o, 32'h0040_0008);
    check_ifid("run2", 32'h2009_0002, 32'h0040_0008, 1'b1);

    // Stall three cycles: everything frozen.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", pc_o, 32'h0040_0008);
      check_ifid("stall", 32'h2009_0002, 32'h0040_0008, 1'b1);
    end
    stall_i = 1'b0;
    tick();
    check("resume.pc", pc_o, 32'h0040_000C);
    check_ifid("resume", 32'h200A_0003, 32'h0040_000C, 1'b1);

    // Taken branch: redirect + flush.
    set_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0020);
    tick();
    check("br.pc", pc_o, 32'h0040_0020);
    check_ifid("br", 32'h0, 32'h0, 1'b0);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("br_next.pc", pc_o, 32'h0040_0024);
    check_ifid("br_next", 32'h2010_0009, 32'h0040_0024, 1'b1);

    // Redirect + stall + flush together.
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0040);
    tick();
    check("rsf.pc", pc_o, 32'h0040_0040);
    check_ifid("rsf", 32'h0, 32'h0, 1'b0);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("rsf_next.pc", pc_o, 32'h0040_0044);
    check_ifid("rsf_next", 32'h2018_0011, 32'h0040_0044, 1'b1);

    // Redirect without flush: delay-slot instruction at old PC is latched.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0100);
    tick();
    check("dslot.pc", pc_o, 32'h0040_0100);
    check_ifid("dslot", 32'h2019_0012, 32'h0040_0048, 1'b1);

    // Misaligned target: PC aligned down, one-cycle error pulse.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0013);
    tick();
    check("mis.pc", pc_o, 32'h0040_0010);
    check("mis.align", {31'd0, align_err_o}, 32'd1);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("mis_next.pc", pc_o, 32'h0040_0014);
    check("mis_next.align", {31'd0, align_err_o}, 32'd0);

    // Wrap-around at top of address space.
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    check("top.pc", pc_o, 32'hFFFF_FFFC);
    check("top.align", {31'd0, align_err_o}, 32'd0);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("wrap.pc", pc_o, 32'h0000_0000);
    check_ifid("wrap", rom_word(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Redirect during stall (no flush): PC moves, IF/ID holds.
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0200);
    tick();
    check("rs.pc", pc_o, 32'h0040_0200);
    check_ifid("rs", rom_word(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Event counters from a clean reset: 4 stall-only cycles, 2 flushes (one with stall).
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("rst2.pc", pc_o, 32'h0040_0000);
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("stat_stall.pc", pc_o, 32'h0040_0000);
    set_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("fl.pc", pc_o, 32'h0040_0004);
    set_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check("flst.pc", pc_o, 32'h0040_0004);
    check_ifid("flst", 32'h0, 32'h0, 1'b0);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check("pre_rst.pc", pc_o, 32'h0040_0008);
    check_ifid("pre_rst", 32'h2009_0002, 32'h0040_0008, 1'b1);
`ifdef FETCH_STATS_EN
    check("stall_cnt", stall_cnt_o, 32'd4);
    check("flush_cnt", flush_cnt_o, 32'd2);
`endif

    // Mid-run reset overrides a simultaneous misaligned redirect.
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0013);
    tick();
    check("mrst.pc", pc_o, 32'h0040_0000);
    check_ifid("mrst", 32'h0, 32'h0, 1'b0);
    check("mrst.align", {31'd0, align_err_o}, 32'd0);
`ifdef FETCH_STATS_EN
    check("mrst.stall_cnt", stall_cnt_o, 32'd0);
    check("mrst.flush_cnt", flush_cnt_o, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
